// File: rtl/sensor_request_scheduler_pkg.sv
// -----------------------------------------------------------------------------
// sensor_request_scheduler_pkg
//
// Shared definitions for the sensor request scheduler:
//   - response codes placed in the first TX byte when no sensor data exists
//   - dispatcher state encoding
//   - frame assembler phase encoding
//   - the queued request word (address byte, command byte)
// -----------------------------------------------------------------------------
package sensor_request_scheduler_pkg;

    localparam logic [7:0] RESP_BAD_ADDR = 8'hFD;
    localparam logic [7:0] RESP_TIMEOUT  = 8'hFF;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT,
        ST_SEND_CODE,
        ST_SEND_DATA
    } disp_state_t;

    typedef enum logic {
        PH_ADDR,
        PH_CMD
    } frame_phase_t;

    // Address in the upper byte so the packed word reads in frame order.
    typedef struct packed {
        logic [7:0] addr;
        logic [7:0] cmd;
    } request_t;

endpackage

// File: rtl/sensor_request_scheduler_fifo.sv
// -----------------------------------------------------------------------------
// request_fifo
//
// Synchronous FIFO for assembled request frames. Read data is shown
// combinationally from the head entry (first-word fall-through).
//
// Ports:
//   clock, reset_n : clock and asynchronous active-low reset
//   push, din      : write request and data; ignored when full unless a pop
//                    happens in the same cycle
//   pop, dout      : read request and head-of-queue data; ignored when empty
//   count          : occupancy, 0..DEPTH
//   full, empty    : occupancy flags
// -----------------------------------------------------------------------------
module request_fifo #(
    parameter int DATA_WIDTH = 16,
    parameter int DEPTH      = 4
) (
    input  logic                    clock,
    input  logic                    reset_n,
    input  logic                    push,
    input  logic                    pop,
    input  logic [DATA_WIDTH-1:0]   din,
    output logic [DATA_WIDTH-1:0]   dout,
    output logic [$clog2(DEPTH):0]  count,
    output logic                    full,
    output logic                    empty
);

    localparam int AW = $clog2(DEPTH);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]         wr_ptr;
    logic [AW-1:0]         rd_ptr;
    logic                  do_push;
    logic                  do_pop;

    assign full    = (count == (AW + 1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop && !empty;
    // A full FIFO still accepts a write when the head leaves in the same cycle.
    assign do_push = push && (!full || do_pop);
    assign dout    = mem[rd_ptr];

    // NOTE: the storage array is deliberately left without a reset; only the
    // pointers and count define which entries are valid, and a reset-free
    // array maps onto plain RAM/register files without a clear network.
    always_ff @(posedge clock) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    // DEPTH is a power of two, so the pointers wrap modulo DEPTH naturally.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/sensor_request_scheduler.sv
// -----------------------------------------------------------------------------
// sensor_request_scheduler
//
// Sits between a UART receiver/transmitter pair and CHANNELS sensor decoders.
// Two-byte frames (address, command) are assembled from the RX byte stream,
// queued, dispatched one at a time to the addressed sensor, and answered with
// a two-byte response (code, data) over a valid/ready TX handshake.
//
// Ports:
//   clock, reset_n   : clock and asynchronous active-low reset
//   rx_valid/rx_data : one-cycle pulse carrying a received byte
//   sensor_enable    : one-hot enable of the addressed channel
//   sensor_request   : command byte for the enabled channel
//   sensor_finished  : per-channel completion pulse
//   sensor_data      : per-channel result, channel k in bits [8k+7:8k]
//   tx_valid/tx_data/tx_ready : response byte handshake
//   queue_count      : request FIFO occupancy
//   overflow_count   : saturating count of frames dropped on a full FIFO
//   busy             : dispatcher is not idle
// -----------------------------------------------------------------------------
module sensor_request_scheduler
    import sensor_request_scheduler_pkg::*;
#(
    parameter int CHANNELS       = 4,
    parameter int DEPTH          = 4,
    parameter int FRAME_TIMEOUT  = 1_000_000,
    parameter int SENSOR_TIMEOUT = 5_000_000
) (
    input  logic                   clock,
    input  logic                   reset_n,
    input  logic                   rx_valid,
    input  logic [7:0]             rx_data,
    output logic [CHANNELS-1:0]    sensor_enable,
    output logic [7:0]             sensor_request,
    input  logic [CHANNELS-1:0]    sensor_finished,
    input  logic [CHANNELS*8-1:0]  sensor_data,
    output logic                   tx_valid,
    output logic [7:0]             tx_data,
    input  logic                   tx_ready,
    output logic [$clog2(DEPTH):0] queue_count,
    output logic [7:0]             overflow_count,
    output logic                   busy
);

    localparam int FTW = $clog2(FRAME_TIMEOUT + 1);
    localparam int STW = $clog2(SENSOR_TIMEOUT + 1);
    localparam int CIW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

    // Timers count from 0, so the last permitted cycle is TIMEOUT-1.
    localparam logic [FTW-1:0] FRAME_LAST  = FTW'(FRAME_TIMEOUT - 1);
    localparam logic [STW-1:0] SENSOR_LAST = STW'(SENSOR_TIMEOUT - 1);

    // ---------------------------------------------------------------------
    // Frame assembler
    // ---------------------------------------------------------------------
    frame_phase_t   phase;
    logic [7:0]     frame_addr;
    logic [FTW-1:0] frame_timer;
    logic           frame_valid;
    request_t       frame_word;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            phase       <= PH_ADDR;
            frame_addr  <= '0;
            frame_timer <= '0;
            frame_valid <= 1'b0;
            frame_word  <= '0;
        end else begin
            frame_valid <= 1'b0;
            case (phase)
                PH_ADDR: begin
                    if (rx_valid) begin
                        frame_addr  <= rx_data;
                        frame_timer <= '0;
                        phase       <= PH_CMD;
                    end
                end
                PH_CMD: begin
                    // A byte on the timeout cycle still completes the frame.
                    if (rx_valid) begin
                        frame_word  <= {frame_addr, rx_data};
                        frame_valid <= 1'b1;
                        phase       <= PH_ADDR;
                    end else if (frame_timer == FRAME_LAST) begin
                        phase <= PH_ADDR;
                    end else begin
                        frame_timer <= frame_timer + 1'b1;
                    end
                end
                default: phase <= PH_ADDR;
            endcase
        end
    end

    // ---------------------------------------------------------------------
    // Request FIFO and overflow accounting
    // ---------------------------------------------------------------------
    logic        fifo_pop;
    logic [15:0] fifo_dout;
    logic        fifo_full;
    logic        fifo_empty;
    logic        frame_drop;

    request_fifo #(
        .DATA_WIDTH (16),
        .DEPTH      (DEPTH)
    ) u_request_fifo (
        .clock   (clock),
        .reset_n (reset_n),
        .push    (frame_valid),
        .pop     (fifo_pop),
        .din     (frame_word),
        .dout    (fifo_dout),
        .count   (queue_count),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    assign frame_drop = frame_valid && fifo_full && !fifo_pop;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            overflow_count <= '0;
        end else if (frame_drop && (overflow_count != 8'hFF)) begin
            overflow_count <= overflow_count + 1'b1;
        end
    end

    // ---------------------------------------------------------------------
    // Dispatcher
    // ---------------------------------------------------------------------
    disp_state_t         state;
    disp_state_t         next_state;
    request_t            work;
    logic [7:0]          resp_code;
    logic [7:0]          resp_data;
    logic [STW-1:0]      sens_timer;
    logic                addr_ok;
    logic [CIW-1:0]      chan_idx;
    logic [CHANNELS-1:0] chan_onehot;
    logic [7:0]          chan_data;
    logic                sensor_hit;
    logic                sensor_expired;

    assign addr_ok     = (work.addr < 8'(CHANNELS));
    assign chan_idx    = work.addr[CIW-1:0];
    assign chan_onehot = CHANNELS'(1) << chan_idx;
    assign chan_data   = sensor_data[{chan_idx, 3'b000} +: 8];
    assign busy        = (state != ST_IDLE);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // NOTE: every signal driven here gets a default before the case, so no
    // path leaves it unassigned (no latch), and blocking '=' is used because
    // this block is pure combinational logic evaluated in order.
    always_comb begin
        next_state     = state;
        fifo_pop       = 1'b0;
        sensor_enable  = '0;
        sensor_request = '0;
        tx_valid       = 1'b0;
        tx_data        = '0;
        sensor_hit     = 1'b0;
        sensor_expired = 1'b0;
        case (state)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop   = 1'b1;
                    next_state = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (addr_ok) begin
                    sensor_enable  = chan_onehot;
                    sensor_request = work.cmd;
                    next_state     = ST_WAIT;
                end else begin
                    next_state = ST_SEND_CODE;
                end
            end
            ST_WAIT: begin
                sensor_enable  = chan_onehot;
                sensor_request = work.cmd;
                // Only the addressed channel's completion counts.
                sensor_hit     = sensor_finished[chan_idx];
                sensor_expired = (sens_timer == SENSOR_LAST);
                if (sensor_hit || sensor_expired) begin
                    next_state = ST_SEND_CODE;
                end
            end
            ST_SEND_CODE: begin
                tx_valid = 1'b1;
                tx_data  = resp_code;
                if (tx_ready) begin
                    next_state = ST_SEND_DATA;
                end
            end
            ST_SEND_DATA: begin
                tx_valid = 1'b1;
                tx_data  = resp_data;
                // Returning to IDLE guarantees a tx_valid gap between responses.
                if (tx_ready) begin
                    next_state = ST_IDLE;
                end
            end
            default: next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            work       <= '0;
            resp_code  <= '0;
            resp_data  <= '0;
            sens_timer <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (fifo_pop) begin
                        work <= request_t'(fifo_dout);
                    end
                end
                ST_ISSUE: begin
                    sens_timer <= '0;
                    if (!addr_ok) begin
                        resp_code <= RESP_BAD_ADDR;
                        resp_data <= '0;
                    end
                end
                ST_WAIT: begin
                    // Success takes priority over a coincident timeout.
                    if (sensor_hit) begin
                        resp_code <= work.cmd;
                        resp_data <= chan_data;
                    end else if (sensor_expired) begin
                        resp_code <= RESP_TIMEOUT;
                        resp_data <= '0;
                    end else begin
                        sens_timer <= sens_timer + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_sensor_request_scheduler.sv
// -----------------------------------------------------------------------------
// tb_sensor_request_scheduler
//
// Frames are issued by the main process; at issue time the expected response
// is derived from the frame and the planned sensor behaviour and queued. A
// sensor model plays out the planned behaviour when a channel is enabled, and
// a TX monitor pairs response bytes and compares them with the queue.
// -----------------------------------------------------------------------------
module tb_sensor_request_scheduler;

    localparam int CHANNELS       = 4;
    localparam int DEPTH          = 4;
    localparam int FRAME_TIMEOUT  = 50;
    localparam int SENSOR_TIMEOUT = 100;
    localparam int NEVER          = 1000;

    logic                  clock = 1'b0;
    logic                  reset_n = 1'b0;
    logic                  rx_valid;
    logic [7:0]            rx_data;
    logic [CHANNELS-1:0]   sensor_enable;
    logic [7:0]            sensor_request;
    logic [CHANNELS-1:0]   sensor_finished;
    logic [CHANNELS*8-1:0] sensor_data;
    logic                  tx_valid;
    logic [7:0]            tx_data;
    logic                  tx_ready;
    logic [2:0]            queue_count;
    logic [7:0]            overflow_count;
    logic                  busy;

    sensor_request_scheduler #(
        .CHANNELS       (CHANNELS),
        .DEPTH          (DEPTH),
        .FRAME_TIMEOUT  (FRAME_TIMEOUT),
        .SENSOR_TIMEOUT (SENSOR_TIMEOUT)
    ) dut (
        .clock           (clock),
        .reset_n         (reset_n),
        .rx_valid        (rx_valid),
        .rx_data         (rx_data),
        .sensor_enable   (sensor_enable),
        .sensor_request  (sensor_request),
        .sensor_finished (sensor_finished),
        .sensor_data     (sensor_data),
        .tx_valid        (tx_valid),
        .tx_data         (tx_data),
        .tx_ready        (tx_ready),
        .queue_count     (queue_count),
        .overflow_count  (overflow_count),
        .busy            (busy)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    typedef struct {
        logic [7:0] code;
        logic [7:0] data;
    } resp_t;

    typedef struct {
        int         ch;
        logic [7:0] cmd;
        int         delay;   // cycles after the enable first appears
        logic [7:0] data;
    } plan_t;

    resp_t exp_q[$];
    plan_t plan_q[$];

    int n_vec      = 0;
    int n_fail     = 0;
    int issued     = 0;
    int received   = 0;
    int ready_mode = 1;      // 0: low, 1: high, 2: random
    bit abort_job  = 1'b0;
    int en_cyc     = -1;
    int cmd_cyc    = -1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        rx_valid = 1'b1;
        rx_data  = b;
        tick(1);
        rx_valid = 1'b0;
        rx_data  = 8'($urandom);
        tick(gap);
    endtask

    // Reference model: the response follows from the address range and from
    // whether the sensor answers within SENSOR_TIMEOUT cycles of its enable.
    task automatic issue_frame(input logic [7:0] addr, input logic [7:0] cmd,
                               input int delay, input logic [7:0] data,
                               input bit accepted, input int gap_mid, input int gap_end);
        resp_t r;
        plan_t p;
        if (accepted) begin
            if (int'(addr) >= CHANNELS) begin
                r = '{8'hFD, 8'h00};
            end else begin
                p = '{int'(addr), cmd, delay, data};
                plan_q.push_back(p);
                if (delay <= SENSOR_TIMEOUT) r = '{cmd, data};
                else                         r = '{8'hFF, 8'h00};
            end
            exp_q.push_back(r);
            issued++;
        end
        send_byte(addr, gap_mid);
        cmd_cyc = cyc;
        send_byte(cmd, gap_end);
    endtask

    task automatic wait_drain(input string name);
        int w = 0;
        while (exp_q.size() != 0 && w < 5000) begin
            tick(1);
            w++;
        end
        if (exp_q.size() != 0) begin
            n_vec++;
            n_fail++;
            $display("FAIL %s: %0d responses outstanding after %0d cycles", name, exp_q.size(), w);
        end
        tick(2);
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, " sensor_enable"},  32'(sensor_enable),  0);
        check({tag, " sensor_request"}, 32'(sensor_request), 0);
        check({tag, " tx_valid"},       32'(tx_valid),       0);
        check({tag, " tx_data"},        32'(tx_data),        0);
        check({tag, " queue_count"},    32'(queue_count),    0);
        check({tag, " overflow_count"}, 32'(overflow_count), 0);
        check({tag, " busy"},           32'(busy),           0);
    endtask

    // TX ready driver
    initial begin
        tx_ready = 1'b0;
        forever begin
            @(posedge clock);
            #1;
            if (ready_mode == 2) tx_ready = ($urandom_range(0, 2) != 0);
            else                 tx_ready = (ready_mode == 1);
        end
    end

    // Sensor model: plays out the next planned behaviour whenever a channel
    // is enabled, and checks the enable/request seen on the way.
    initial begin : sensor_model
        plan_t               p;
        int                  hold;
        bit                  done;
        logic [CHANNELS-1:0] exp_en;
        logic [CHANNELS-1:0] spur;
        sensor_finished = '0;
        sensor_data     = '0;
        forever begin
            @(posedge clock);
            #1;
            sensor_finished = '0;
            sensor_data     = 32'($urandom);
            if (reset_n && sensor_enable != '0) begin
                en_cyc = cyc;
                if (plan_q.size() == 0) begin
                    check("unplanned sensor_enable", 32'(sensor_enable), 0);
                end else begin
                    p      = plan_q.pop_front();
                    exp_en = CHANNELS'(1) << p.ch;
                    check("sensor_enable channel", 32'(sensor_enable), 32'(exp_en));
                    check("sensor_request", 32'(sensor_request), 32'(p.cmd));
                    hold = 0;
                    done = 1'b0;
                    for (int k = 1; k <= SENSOR_TIMEOUT + 20 && !done; k++) begin
                        tick(1);
                        sensor_data     = 32'($urandom);
                        spur            = CHANNELS'($urandom);
                        spur[p.ch]      = 1'b0;
                        sensor_finished = spur;
                        if (sensor_enable == '0) begin
                            done = 1'b1;
                        end else begin
                            hold++;
                            check("enable held stable", 32'(sensor_enable), 32'(exp_en));
                            check("request held stable", 32'(sensor_request), 32'(p.cmd));
                            if (k == p.delay) begin
                                sensor_finished[p.ch]       = 1'b1;
                                sensor_data[p.ch*8 +: 8]    = p.data;
                            end
                        end
                    end
                    sensor_finished = '0;
                    if (!done) check("sensor_enable released", 32'(sensor_enable), 0);
                    if (!abort_job)
                        check("enable cycles after issue", hold,
                              (p.delay <= SENSOR_TIMEOUT) ? p.delay : SENSOR_TIMEOUT);
                end
            end
        end
    end

    // TX monitor / scoreboard
    initial begin : tx_monitor
        resp_t      r;
        logic [7:0] code_b;
        logic [7:0] stall_data;
        bit         have_code = 1'b0;
        bit         stalled   = 1'b0;
        bit         need_gap  = 1'b0;
        forever begin
            @(negedge clock);
            if (!reset_n) begin
                have_code = 1'b0;
                stalled   = 1'b0;
                need_gap  = 1'b0;
            end else begin
                if (need_gap) begin
                    check("tx_valid gap between responses", 32'(tx_valid), 0);
                    need_gap = 1'b0;
                end
                if (stalled) begin
                    check("tx_valid held under backpressure", 32'(tx_valid), 1);
                    check("tx_data held under backpressure", 32'(tx_data), 32'(stall_data));
                end
                stalled    = tx_valid && !tx_ready;
                stall_data = tx_data;
                if (tx_valid && tx_ready) begin
                    if (!have_code) begin
                        code_b    = tx_data;
                        have_code = 1'b1;
                    end else begin
                        have_code = 1'b0;
                        need_gap  = 1'b1;
                        received++;
                        if (exp_q.size() == 0) begin
                            n_vec++;
                            n_fail++;
                            $display("FAIL unexpected response: got 0x%0h 0x%0h, none expected", code_b, tx_data);
                        end else begin
                            r = exp_q.pop_front();
                            check("response code", 32'(code_b), 32'(r.code));
                            check("response data", 32'(tx_data), 32'(r.data));
                        end
                    end
                end
            end
        end
    end

    // Main stimulus
    initial begin : main
        logic [7:0] a;
        int         d;
        int         w;
        rx_valid = 1'b0;
        rx_data  = '0;
        repeat (3) @(posedge clock);
        #1;
        check_outputs_zero("reset");
        reset_n = 1'b1;
        tick(2);

        // Happy path with latency check
        issue_frame(8'h02, 8'h10, 20, 8'h5A, 1'b1, 0, 0);
        wait_drain("happy path");
        check("enable latency from command byte", en_cyc - cmd_cyc, 3);
        check("busy after response", 32'(busy), 0);

        // Bad address
        issue_frame(8'h07, 8'h21, 5, 8'h00, 1'b1, 0, 0);
        wait_drain("bad address");

        // Sensor timeout, then finished on the last permitted cycle
        issue_frame(8'h01, 8'h33, NEVER, 8'h00, 1'b1, 0, 0);
        wait_drain("sensor timeout");
        issue_frame(8'h03, 8'h34, SENSOR_TIMEOUT, 8'hC3, 1'b1, 0, 0);
        wait_drain("finish on timeout cycle");

        // Frame timeout: command one cycle too late becomes a new address
        send_byte(8'h01, FRAME_TIMEOUT);
        issue_frame(8'h03, 8'h44, 12, 8'h77, 1'b1, 0, 0);
        wait_drain("frame timeout");
        // Command on the last permitted cycle completes the frame
        issue_frame(8'h02, 8'h55, 5, 8'h99, 1'b1, FRAME_TIMEOUT - 1, 0);
        wait_drain("frame timeout boundary");

        // Overflow with TX blocked
        ready_mode = 0;
        tick(2);
        for (int i = 0; i < 6; i++)
            issue_frame(8'(i % CHANNELS), 8'(8'h80 + i), 3, 8'(8'h40 + i), (i < 5), 0, 0);
        tick(20);
        check("queue_count when full", 32'(queue_count), DEPTH);
        check("overflow_count", 32'(overflow_count), 1);
        check("busy while blocked", 32'(busy), 1);
        ready_mode = 1;
        wait_drain("overflow drain");

        // TX backpressure held for 30+ cycles in SEND_CODE
        ready_mode = 0;
        tick(2);
        issue_frame(8'h06, 8'h01, 5, 8'h00, 1'b1, 0, 0);
        tick(35);
        check("tx_valid under backpressure", 32'(tx_valid), 1);
        check("tx_data under backpressure", 32'(tx_data), 32'hFD);
        ready_mode = 1;
        wait_drain("backpressure");

        // Randomized traffic, never more than DEPTH outstanding
        ready_mode = 2;
        for (int i = 0; i < 40; i++) begin
            w = 0;
            while (issued - received >= DEPTH && w < 3000) begin
                tick(1);
                w++;
            end
            if (w >= 3000) begin
                n_vec++;
                n_fail++;
                $display("FAIL random traffic: responses stalled at frame %0d", i);
            end
            a = ($urandom_range(0, 4) == 0) ? 8'($urandom_range(4, 255)) : 8'($urandom_range(0, 3));
            case ($urandom_range(0, 7))
                0:       d = SENSOR_TIMEOUT;
                1:       d = NEVER;
                default: d = $urandom_range(1, 30);
            endcase
            issue_frame(a, 8'($urandom), d, 8'($urandom), 1'b1,
                        $urandom_range(0, 3), $urandom_range(0, 3));
        end
        ready_mode = 1;
        wait_drain("random traffic");

        // Reset in WAIT with more frames queued
        issue_frame(8'h00, 8'h66, NEVER, 8'h00, 1'b1, 0, 0);
        issue_frame(8'h01, 8'h67, 4, 8'h11, 1'b1, 0, 0);
        issue_frame(8'h05, 8'h68, 4, 8'h00, 1'b1, 0, 0);
        tick(10);
        check("busy before reset", 32'(busy), 1);
        check("enable before reset", 32'(sensor_enable), 32'h1);
        abort_job = 1'b1;
        @(posedge clock);
        #3;
        reset_n = 1'b0;
        #1;
        check_outputs_zero("async reset");
        exp_q.delete();
        plan_q.delete();
        issued   = 0;
        received = 0;
        tick(3);
        reset_n = 1'b1;
        tick(60);
        check("queue_count after reset", 32'(queue_count), 0);
        check("busy after reset", 32'(busy), 0);
        abort_job = 1'b0;
        issue_frame(8'h03, 8'h12, 7, 8'hAB, 1'b1, 0, 0);
        wait_drain("recovery after reset");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

    initial begin : watchdog
        #400_000;
        n_vec++;
        n_fail++;
        $display("FAIL watchdog: simulation did not complete in time");
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $fatal(1, "watchdog expired");
    end

endmodule
